// File: rtl/stream_arb_mux_if.sv
// Bundle of the N:1 frame mux: PORTS input streams packed side by side plus one
// output stream tagged with its source port.
interface stream_arb_mux_if #(
  parameter int PORTS      = 4,
  parameter int DATA_WIDTH = 8
);
  localparam int IdW = $clog2(PORTS);

  // A beat moves on a rising clk edge where valid and ready are both high.
  // Once valid is raised, data/last stay put until that edge.
  logic [PORTS*DATA_WIDTH-1:0] s_data;
  logic [PORTS-1:0]            s_valid;
  logic [PORTS-1:0]            s_last;
  logic [PORTS-1:0]            s_ready;
  logic [DATA_WIDTH-1:0]       m_data;
  logic                        m_valid;
  logic                        m_last;
  logic [IdW-1:0]              m_id;
  logic                        m_ready;

  modport slave (
    input  s_data, s_valid, s_last, m_ready,
    output s_ready, m_data, m_valid, m_last, m_id
  );

  modport master (
    output s_data, s_valid, s_last, m_ready,
    input  s_ready, m_data, m_valid, m_last, m_id
  );
endinterface

// File: rtl/stream_arb_mux.sv
// Round-robin N:1 frame multiplexer: a granted frame is forwarded whole, then the
// output goes through a two-entry skid so every output and s_ready is registered.
module stream_arb_mux #(
  parameter int PORTS                 = 4,
  parameter int DATA_WIDTH            = 8,
  parameter bit LAST_ENABLE           = 1'b1,
  parameter bit ARB_LSB_HIGH_PRIORITY = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  stream_arb_mux_if.slave bus_io
);
  localparam int IdW = $clog2(PORTS);
  localparam int BW  = IdW + 1 + DATA_WIDTH;

  logic [PORTS-1:0] grant_q, grant_d;
  logic [PORTS-1:0] mask_q, mask_d;
  logic             grant_valid_q, grant_valid_d;
  logic [IdW-1:0]   grant_idx_q, grant_idx_d;
  logic [PORTS-1:0] request, masked_req, ack, s_ready;
  logic [IdW-1:0]   req_idx, mreq_idx, sel_idx;

  logic             ready_int_q, ready_int_d;
  logic             m_valid_q, m_valid_d;
  logic             temp_valid_q, temp_valid_d;
  logic [BW-1:0]    m_beat_q, m_beat_d;
  logic [BW-1:0]    temp_beat_q, temp_beat_d;
  logic             in_valid;
  logic [BW-1:0]    in_beat;

  assign request    = bus_io.s_valid;
  assign masked_req = request & mask_q;
  assign s_ready    = grant_q & {PORTS{grant_valid_q & ready_int_q}};
  // The grant is released only by the transfer of a frame's final beat.
  assign ack        = grant_q & bus_io.s_valid & s_ready & (bus_io.s_last | {PORTS{!LAST_ENABLE}});

  always_comb begin
    req_idx  = '0;
    mreq_idx = '0;
    if (ARB_LSB_HIGH_PRIORITY) begin
      for (int i = PORTS - 1; i >= 0; i--) begin
        if (request[i])    req_idx  = IdW'(i);
        if (masked_req[i]) mreq_idx = IdW'(i);
      end
    end else begin
      for (int i = 0; i < PORTS; i++) begin
        if (request[i])    req_idx  = IdW'(i);
        if (masked_req[i]) mreq_idx = IdW'(i);
      end
    end
  end

  always_comb begin
    grant_d       = grant_q;
    grant_valid_d = grant_valid_q;
    grant_idx_d   = grant_idx_q;
    mask_d        = mask_q;
    sel_idx       = (|masked_req) ? mreq_idx : req_idx;
    if (!grant_valid_q || (|ack)) begin
      grant_d       = '0;
      grant_valid_d = 1'b0;
      grant_idx_d   = '0;
      if (|request) begin
        grant_valid_d = 1'b1;
        grant_idx_d   = sel_idx;
        // Mask keeps only ports after the winner, so the next pick rotates past it.
        for (int i = 0; i < PORTS; i++) begin
          grant_d[i] = (i == int'(sel_idx));
          mask_d[i]  = ARB_LSB_HIGH_PRIORITY ? (i > int'(sel_idx)) : (i < int'(sel_idx));
        end
      end
    end
  end

  assign in_valid = |(bus_io.s_valid & s_ready);
  assign in_beat  = {grant_idx_q,
                     bus_io.s_last[grant_idx_q] | !LAST_ENABLE,
                     bus_io.s_data[int'(grant_idx_q)*DATA_WIDTH +: DATA_WIDTH]};

  always_comb begin
    m_valid_d    = m_valid_q;
    m_beat_d     = m_beat_q;
    temp_valid_d = temp_valid_q;
    temp_beat_d  = temp_beat_q;
    // Ready is computed a cycle ahead so upstream never sees m_ready combinationally.
    ready_int_d  = bus_io.m_ready | (!temp_valid_q & (!m_valid_q | !in_valid));
    if (ready_int_q) begin
      if (bus_io.m_ready || !m_valid_q) begin
        m_valid_d = in_valid;
        if (in_valid) m_beat_d = in_beat;
      end else begin
        temp_valid_d = in_valid;
        if (in_valid) temp_beat_d = in_beat;
      end
    end else if (bus_io.m_ready) begin
      m_valid_d    = temp_valid_q;
      m_beat_d     = temp_beat_q;
      temp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_q       <= '0;
      mask_q        <= '0;
      grant_valid_q <= 1'b0;
      grant_idx_q   <= '0;
      ready_int_q   <= 1'b0;
      m_valid_q     <= 1'b0;
      m_beat_q      <= '0;
      temp_valid_q  <= 1'b0;
      temp_beat_q   <= '0;
    end else begin
      grant_q       <= grant_d;
      mask_q        <= mask_d;
      grant_valid_q <= grant_valid_d;
      grant_idx_q   <= grant_idx_d;
      ready_int_q   <= ready_int_d;
      m_valid_q     <= m_valid_d;
      m_beat_q      <= m_beat_d;
      temp_valid_q  <= temp_valid_d;
      temp_beat_q   <= temp_beat_d;
    end
  end

  assign bus_io.s_ready = s_ready;
  assign bus_io.m_valid = m_valid_q;
  assign {bus_io.m_id, bus_io.m_last, bus_io.m_data} = m_beat_q;
endmodule

// File: tb/tb_stream_arb_mux.sv
// Bench for stream_arb_mux: per-port beat queues and frame ordering rules
// checked against both a framed instance and a LAST_ENABLE=0 instance.
module tb_stream_arb_mux;
  localparam int PORTS = 4;
  localparam int DW    = 8;
  localparam int IW    = $clog2(PORTS);

  typedef struct packed {
    logic [IW-1:0] id;
    logic          last;
    logic [DW-1:0] data;
    logic [31:0]   t;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  stream_arb_mux_if #(.PORTS(PORTS), .DATA_WIDTH(DW)) bus ();
  stream_arb_mux_if #(.PORTS(PORTS), .DATA_WIDTH(DW)) bus2 ();

  stream_arb_mux #(.PORTS(PORTS), .DATA_WIDTH(DW), .LAST_ENABLE(1'b1),
                   .ARB_LSB_HIGH_PRIORITY(1'b1))
    dut (.clk(clk), .rst(rst), .bus_io(bus));

  stream_arb_mux #(.PORTS(PORTS), .DATA_WIDTH(DW), .LAST_ENABLE(1'b0),
                   .ARB_LSB_HIGH_PRIORITY(1'b1))
    dut_nolast (.clk(clk), .rst(rst), .bus_io(bus2));

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // reference model: beats waiting upstream, beats owed at the output per port
  logic [DW:0] src_q[PORTS][$];
  logic [DW:0] exp_q[PORTS][$];
  beat_t       log_q[$];
  int          hold[PORTS];
  int          gap_pct = 0;
  int          rdy_pct = 100;
  bit          use_pat = 1'b0;
  int          pat_idx = 0;
  logic [3:0]  rdy_pat = 4'b1001;
  logic        prev_stall = 1'b0;
  logic [IW+DW:0] prev_out = '0;
  bit          in_frame = 1'b0;
  logic [IW-1:0] frame_id = '0;

  function automatic int pending();
    int n;
    n = 0;
    for (int p = 0; p < PORTS; p++) n += src_q[p].size() + exp_q[p].size();
    return n;
  endfunction

  function automatic int next_rr(input int last, input logic [PORTS-1:0] req);
    int p;
    for (int k = 1; k <= PORTS; k++) begin
      p = (last + k) % PORTS;
      if (req[p]) return p;
    end
    return -1;
  endfunction

  task automatic clear_model();
    for (int p = 0; p < PORTS; p++) begin
      src_q[p].delete();
      exp_q[p].delete();
      hold[p] = 0;
    end
    log_q.delete();
    prev_stall = 1'b0;
    in_frame   = 1'b0;
    frame_id   = '0;
    use_pat    = 1'b0;
    pat_idx    = 0;
    gap_pct    = 0;
    rdy_pct    = 100;
  endtask

  task automatic drive_idle();
    bus.s_valid  = '0;
    bus.s_last   = '0;
    bus.s_data   = '0;
    bus.m_ready  = 1'b1;
    bus2.s_valid = '0;
    bus2.s_last  = '0;
    bus2.s_data  = '0;
    bus2.m_ready = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive_idle();
    clear_model();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic add_frame(input int p, input int len);
    for (int k = 0; k < len; k++)
      src_q[p].push_back({(k == len - 1), DW'($urandom_range(0, 255))});
  endtask

  // driver + monitor for one cycle of the framed instance
  task automatic step();
    logic [PORTS-1:0] v;
    logic [DW:0]      b;
    logic [DW:0]      e;
    int               id;
    @(negedge clk);
    v = '0;
    for (int p = 0; p < PORTS; p++) begin
      if (hold[p] > 0) begin
        hold[p]--;
      end else if (src_q[p].size() > 0 && int'($urandom_range(0, 99)) >= gap_pct) begin
        v[p] = 1'b1;
        b = src_q[p][0];
        bus.s_last[p] = b[DW];
        bus.s_data[p*DW +: DW] = b[DW-1:0];
      end
    end
    bus.s_valid = v;
    bus.m_ready = use_pat ? rdy_pat[pat_idx % 4] : (int'($urandom_range(0, 99)) < rdy_pct);
    pat_idx++;
    if (prev_stall) begin
      n_checks++;
      if ({bus.m_valid, bus.m_id, bus.m_last, bus.m_data} !== {1'b1, prev_out}) begin
        n_errors++;
        $display("FAIL stall_hold: got %h expected %h", {bus.m_valid, bus.m_id, bus.m_last, bus.m_data}, {1'b1, prev_out});
      end
    end
    n_checks++;
    if ((bus.s_ready & (bus.s_ready - PORTS'(1))) !== '0) begin
      n_errors++;
      $display("FAIL s_ready_onehot: got %b expected at most one bit", bus.s_ready);
    end
    for (int p = 0; p < PORTS; p++) begin
      if (v[p] && bus.s_ready[p]) exp_q[p].push_back(src_q[p].pop_front());
    end
    if (bus.m_valid && bus.m_ready) begin
      id = int'(bus.m_id);
      n_checks++;
      if (exp_q[id].size() == 0) begin
        n_errors++;
        $display("FAIL out_beat: got id %0d data %h, expected no beat from that port", id, bus.m_data);
      end else begin
        e = exp_q[id].pop_front();
        if ({bus.m_last, bus.m_data} !== e) begin
          n_errors++;
          $display("FAIL out_beat: port %0d got last/data %h expected %h", id, {bus.m_last, bus.m_data}, e);
        end
      end
      if (in_frame) begin
        n_checks++;
        if (bus.m_id !== frame_id) begin
          n_errors++;
          $display("FAIL interleave: got id %0d expected %0d", bus.m_id, frame_id);
        end
      end
      in_frame = !bus.m_last;
      frame_id = bus.m_id;
      log_q.push_back({bus.m_id, bus.m_last, bus.m_data, 32'(cyc)});
    end
    prev_stall = bus.m_valid && !bus.m_ready;
    prev_out   = {bus.m_id, bus.m_last, bus.m_data};
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while (pending() > 0 && n < budget) begin
      step();
      n++;
    end
    n_checks++;
    if (pending() != 0) begin
      n_errors++;
      $display("FAIL %s_drain: %0d beats outstanding after %0d cycles, expected 0", name, pending(), budget);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    drive_idle();
    repeat (2) @(negedge clk);
    n_checks++;
    if ({bus.m_valid, bus.m_last, bus.m_id, bus.m_data} !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs: got v%b l%b id%0d d%h expected all 0", bus.m_valid, bus.m_last, bus.m_id, bus.m_data);
    end
    n_checks++;
    if (bus.s_ready !== '0) begin
      n_errors++;
      $display("FAIL reset_s_ready: got %b expected 0", bus.s_ready);
    end
    n_checks++;
    if ({bus2.m_valid, bus2.m_last, bus2.m_id, bus2.m_data, bus2.s_ready} !== '0) begin
      n_errors++;
      $display("FAIL reset_nolast: got %h expected 0", {bus2.m_valid, bus2.m_last, bus2.m_id, bus2.m_data, bus2.s_ready});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    int t0;
    do_reset();
    add_frame(0, 3);
    t0 = cyc + 1;
    drain("single", 100);
    n_checks++;
    if (log_q.size() != 3) begin
      n_errors++;
      $display("FAIL single_count: got %0d beats expected 3", log_q.size());
    end
    for (int k = 0; k < log_q.size(); k++) begin
      n_checks++;
      if (int'(log_q[k].t) - t0 != 2 + k || log_q[k].id !== 2'd0 || log_q[k].last !== (k == 2)) begin
        n_errors++;
        $display("FAIL single_beat%0d: got cycle %0d id %0d last %b expected cycle %0d id 0 last %b",
                 k, int'(log_q[k].t) - t0, log_q[k].id, log_q[k].last, 2 + k, (k == 2));
      end
    end
  endtask

  task automatic test_arbitration();
    int t0;
    do_reset();
    for (int p = 0; p < 3; p++) add_frame(p, 2);
    t0 = cyc + 1;
    drain("arb", 100);
    n_checks++;
    if (log_q.size() != 6) begin
      n_errors++;
      $display("FAIL arb_count: got %0d beats expected 6", log_q.size());
    end
    for (int k = 0; k < log_q.size(); k++) begin
      n_checks++;
      if (int'(log_q[k].id) != k / 2 || int'(log_q[k].t) - t0 != 2 + k) begin
        n_errors++;
        $display("FAIL arb_beat%0d: got id %0d cycle %0d expected id %0d cycle %0d",
                 k, log_q[k].id, int'(log_q[k].t) - t0, k / 2, 2 + k);
      end
    end
  endtask

  task automatic test_grant_hold();
    do_reset();
    add_frame(1, 3);
    add_frame(2, 2);
    step();
    step();
    n_checks++;
    if (src_q[1].size() != 2) begin
      n_errors++;
      $display("FAIL hold_first_xfer: got %0d beats left on port 1 expected 2", src_q[1].size());
    end
    hold[1] = 3;
    for (int k = 0; k < 3; k++) begin
      step();
      n_checks++;
      if (bus.s_ready !== 4'b0010) begin
        n_errors++;
        $display("FAIL hold_gap%0d: got s_ready %b expected 0010", k, bus.s_ready);
      end
    end
    drain("hold", 100);
    for (int k = 0; k < log_q.size(); k++) begin
      n_checks++;
      if (int'(log_q[k].id) != (k < 3 ? 1 : 2)) begin
        n_errors++;
        $display("FAIL hold_order%0d: got id %0d expected %0d", k, log_q[k].id, (k < 3 ? 1 : 2));
      end
    end
  endtask

  task automatic test_backpressure();
    int   n;
    bit   started;
    logic pm;
    do_reset();
    use_pat = 1'b1;
    add_frame(0, 8);
    add_frame(1, 8);
    add_frame(0, 4);
    n  = 0;
    pm = 1'b1;
    while (pending() > 0 && n < 400) begin
      started = log_q.size() > 0;
      step();
      n++;
      if (started && pm == 1'b0) begin
        n_checks++;
        if (bus.s_ready !== '0) begin
          n_errors++;
          $display("FAIL bp_s_ready: got %b expected 0 one cycle after m_ready=0", bus.s_ready);
        end
      end
      pm = bus.m_ready;
    end
    n_checks++;
    if (pending() != 0 || log_q.size() != 20) begin
      n_errors++;
      $display("FAIL bp_count: got %0d beats out %0d pending expected 20 out 0 pending", log_q.size(), pending());
    end
  endtask

  task automatic test_random();
    int total;
    do_reset();
    gap_pct = 30;
    rdy_pct = 65;
    total   = 0;
    for (int f = 0; f < 40; f++) begin
      int len;
      len = $urandom_range(1, 5);
      add_frame($urandom_range(0, PORTS - 1), len);
      total += len;
    end
    drain("random", 4000);
    n_checks++;
    if (log_q.size() != total) begin
      n_errors++;
      $display("FAIL random_count: got %0d beats expected %0d", log_q.size(), total);
    end
  endtask

  task automatic test_no_last();
    logic [DW-1:0] cnt[PORTS];
    logic [DW-1:0] ocnt[PORTS];
    logic [DW-1:0] base;
    int            last_id;
    int            eid;
    int            got;
    int            n;
    do_reset();
    for (int p = 0; p < PORTS; p++) begin
      cnt[p]  = '0;
      ocnt[p] = '0;
    end
    last_id = -1;
    got     = 0;
    n       = 0;
    while (got < 8 && n < 60) begin
      @(negedge clk);
      n++;
      bus2.s_valid = 4'b1001;
      bus2.s_last  = 4'($urandom_range(0, 15));
      bus2.s_data[0 +: DW]    = cnt[0];
      bus2.s_data[3*DW +: DW] = 8'h80 + cnt[3];
      bus2.m_ready = 1'b1;
      if (bus2.m_valid) begin
        eid  = next_rr(last_id, 4'b1001);
        base = (eid == 3) ? 8'h80 : 8'h00;
        n_checks++;
        if (int'(bus2.m_id) != eid || bus2.m_last !== 1'b1 || bus2.m_data !== base + ocnt[eid]) begin
          n_errors++;
          $display("FAIL nolast_beat%0d: got id %0d last %b data %h expected id %0d last 1 data %h",
                   got, bus2.m_id, bus2.m_last, bus2.m_data, eid, base + ocnt[eid]);
        end
        if (eid >= 0) ocnt[eid] = ocnt[eid] + 1'b1;
        last_id = int'(bus2.m_id);
        got++;
      end
      if (bus2.s_ready[0]) cnt[0] = cnt[0] + 1'b1;
      if (bus2.s_ready[3]) cnt[3] = cnt[3] + 1'b1;
    end
    n_checks++;
    if (got != 8) begin
      n_errors++;
      $display("FAIL nolast_count: got %0d beats expected 8", got);
    end
    @(negedge clk);
    bus2.s_valid = '0;
  endtask

  task automatic test_mid_reset();
    int t0;
    do_reset();
    add_frame(1, 4);
    repeat (3) step();
    n_checks++;
    if (bus.m_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL midrst_pre: got m_valid %b expected 1", bus.m_valid);
    end
    @(negedge clk);
    rst = 1'b1;
    bus.s_valid = '0;
    @(negedge clk);
    n_checks++;
    if (bus.m_valid !== 1'b0 || bus.s_ready !== '0) begin
      n_errors++;
      $display("FAIL midrst_clear: got m_valid %b s_ready %b expected 0 and 0000", bus.m_valid, bus.s_ready);
    end
    clear_model();
    rst = 1'b0;
    @(negedge clk);
    add_frame(2, 3);
    t0 = cyc + 1;
    drain("midrst", 100);
    n_checks++;
    if (log_q.size() != 3) begin
      n_errors++;
      $display("FAIL midrst_count: got %0d beats expected 3", log_q.size());
    end
    for (int k = 0; k < log_q.size(); k++) begin
      n_checks++;
      if (log_q[k].id !== 2'd2 || int'(log_q[k].t) - t0 != 2 + k) begin
        n_errors++;
        $display("FAIL midrst_beat%0d: got id %0d cycle %0d expected id 2 cycle %0d",
                 k, log_q[k].id, int'(log_q[k].t) - t0, 2 + k);
      end
    end
  endtask

  initial begin
    drive_idle();
    clear_model();
    test_reset();
    test_single();
    test_arbitration();
    test_grant_hold();
    test_backpressure();
    test_random();
    test_no_last();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
